// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and word constants for the imem loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_word_assembler.sv
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs four accepted bytes into a little-endian 32-bit word and
//               flags the cycle in which the fourth byte is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [23:0] shift_q;
    logic [23:0] shift_d;

    // The word is presented combinationally with the fourth byte so the
    // consumer can act in the same cycle and no idle slot is wasted.
    assign word_o       = {data_i, shift_q};
    assign word_valid_o = valid_i && (cnt_q == c_LAST_BYTE);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {data_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot-time loader: length-prefixed byte stream -> imem writes,
//               holds the core in reset until the image is in place.
//               Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic [31:0]               o_instr_addr,
    output logic [31:0]               o_instr_wr_data,
    output logic [3:0]                o_instr_size,
    output logic                      o_instr_write,
    output logic                      o_instr_read,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_core_rst,
    output logic [MEM_ADDR_WIDTH-2:0] o_words_written
);

    localparam int          CW          = MEM_ADDR_WIDTH - 1;
    localparam logic [31:0] c_MAX_WORDS = 32'(2 ** (MEM_ADDR_WIDTH - 2));

    loader_state_e state_q;
    loader_state_e state_d;
    logic [CW-1:0] words_q;
    logic [CW-1:0] words_d;
    logic [CW-1:0] len_q;
    logic [CW-1:0] len_d;
    logic [31:0]   buf_q;
    logic [31:0]   buf_d;
    logic [CW-1:0] words_inc;

    logic          asm_clear;
    logic          rx_accept;
    logic [31:0]   asm_word;
    logic          asm_word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q;
    logic [31:0]   sum_d;
    localparam loader_state_e c_AFTER_LAST = ST_CSUM;
`else
    localparam loader_state_e c_AFTER_LAST = ST_DONE;
`endif

    assign rx_accept = i_rx_valid && o_rx_ready;
    assign words_inc = words_q + CW'(1);

    byte_word_assembler u_asm (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .clear_i      (asm_clear),
        .valid_i      (rx_accept),
        .data_i       (i_rx_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        len_d     = len_q;
        buf_d     = buf_q;
        asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d   = ST_LEN;
                    words_d   = '0;
                    len_d     = '0;
                    asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = 32'd0;
`endif
                end
            end
            ST_LEN: begin
                if (asm_word_valid) begin
                    if (asm_word == 32'd0) begin
                        state_d = c_AFTER_LAST;
                    end else if (asm_word > c_MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = asm_word[CW-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (asm_word_valid) begin
                    buf_d   = asm_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                words_d = words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + buf_q;
`endif
                state_d = (words_inc == len_q) ? c_AFTER_LAST : ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (asm_word_valid) begin
                    state_d = (asm_word == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            len_q   <= '0;
            buf_q   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // All port outputs decode directly from the registered state.
    assign o_rx_ready      = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                             (state_q == ST_CSUM);
    assign o_instr_write   = (state_q == ST_WRITE);
    assign o_instr_size    = (state_q == ST_WRITE) ? FULL_WORD_MASK : 4'b0000;
    assign o_instr_read    = 1'b0;
    assign o_instr_addr    = BASE_ADDR + (32'(words_q) << 2);
    assign o_instr_wr_data = buf_q;
    assign o_busy          = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                             (state_q == ST_WRITE) || (state_q == ST_CSUM);
    assign o_done          = (state_q == ST_DONE);
    assign o_error         = (state_q == ST_ERROR);
    assign o_core_rst      = (state_q != ST_DONE);
    assign o_words_written = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader (expected writes queued as the
//               stream is driven, popped by the write monitor).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [31:0]   instr_addr;
    logic [31:0]   instr_wr_data;
    logic [3:0]    instr_size;
    logic          instr_write;
    logic          instr_read;
    logic          busy;
    logic          done;
    logic          error;
    logic          core_rst;
    logic [AW-2:0] words_written;

    always #5 clk = ~clk;

    imem_loader #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_rx_ready      (rx_ready),
        .o_instr_addr    (instr_addr),
        .o_instr_wr_data (instr_wr_data),
        .o_instr_size    (instr_size),
        .o_instr_write   (instr_write),
        .o_instr_read    (instr_read),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_core_rst      (core_rst),
        .o_words_written (words_written)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic        prev_wr  = 1'b0;
    logic [31:0] words[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (instr_write) begin
            n_writes++;
            chk("wr_one_cycle", 32'(prev_wr), 32'd0);
            chk("wr_ready_low", 32'(rx_ready), 32'd0);
            chk("wr_size", 32'(instr_size), 32'hF);
            chk("wr_read_low", 32'(instr_read), 32'd0);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", instr_addr, exp_e.addr);
                chk("wr_data", instr_wr_data, exp_e.data);
            end
        end
        prev_wr <= instr_write;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk("byte_timeout", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || error) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", 32'(done || error), 32'd1);
    endtask

    // Full framed load of n words from words[]; trailer only when checksums are built.
    task automatic do_load(input int n, input bit gaps, input bit bad_csum);
        logic [31:0] sum;
        sum = 32'd0;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_core_rst", 32'(core_rst), 32'd1);
        chk("start_flags", 32'({done, error}), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (!bad_csum) exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
            else exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
            sum = sum + words[i];
        end
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) send_word(words[i], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(bad_csum ? 32'd0 : sum, gaps);
`endif
        wait_end();
    endtask

    task automatic check_done(input int n, input int wr_before);
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("error", 32'(error), 32'd0);
        chk("core_rst", 32'(core_rst), 32'd0);
        chk("busy", 32'(busy), 32'd0);
        chk("words_written", 32'(words_written), 32'(n));
        chk("writes_seen", 32'(n_writes - wr_before), 32'(n));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int wr0;

    initial begin
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h12345678;
        words[2] = 32'h0;
        words[3] = 32'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_write", 32'(instr_write), 32'd0);
        chk("rst_read", 32'(instr_read), 32'd0);
        chk("rst_size", 32'(instr_size), 32'd0);
        chk("rst_addr", instr_addr, BASE);
        chk("rst_wdata", instr_wr_data, 32'd0);
        chk("rst_flags", 32'({busy, done, error}), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_words", 32'(words_written), 32'd0);

        // Two-word load at full rate
        wr0 = n_writes;
        do_load(2, 1'b0, 1'b0);
        check_done(2, wr0);

        // Zero-length image
        wr0 = n_writes;
        do_load(0, 1'b0, 1'b0);
        check_done(0, wr0);

        // Length overflow: 1025 words > capacity 1024
        wr0 = n_writes;
        pulse_start();
        send_word(32'd1025, 1'b0);
        wait_end();
        @(negedge clk);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_core_rst", 32'(core_rst), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_writes", 32'(n_writes - wr0), 32'd0);

        // Same two-word load with random gaps in the byte stream
        repeat (3) begin
            wr0 = n_writes;
            do_load(2, 1'b1, 1'b0);
            check_done(2, wr0);
        end

        // Reset after six bytes, then a clean one-word load
        wr0 = n_writes;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
        chk("mid_rst_words", 32'(words_written), 32'd0);
        words[0] = 32'hCAFEF00D;
        do_load(1, 1'b0, 1'b0);
        check_done(1, wr0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum trailer mismatch must end in ERROR after the writes
        words[0] = 32'hDEADBEEF;
        wr0 = n_writes;
        do_load(2, 1'b0, 1'b1);
        @(negedge clk);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_core_rst", 32'(core_rst), 32'd1);
        chk("csum_bad_writes", 32'(n_writes - wr0), 32'd2);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
